// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem reads, buffers returned words with their PCs
// in a small circular queue, and hands them downstream over valid/ready; redirect flushes.
module fetch_unit #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [7:0]               imem_addr,
  input  logic [7:0]               imem_data,
  output logic [7:0]               instr,
  output logic [7:0]               instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [7:0]               redirect_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc;
  } entry_t;

  entry_t          queue_q [DEPTH];
  entry_t          queue_d [DEPTH];
  logic [7:0]      fetch_pc_q, fetch_pc_d;
  logic [7:0]      inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW:0]     occ;
  logic            push, pop;

  // Outstanding request reserves a slot, so a capture can never overflow the queue.
  assign occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imem_req  = rst_n & ~redirect & (occ < DEPTH_W);
  assign imem_addr = fetch_pc_q;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? queue_q[rd_ptr_q].instr : 8'h00;
  assign instr_pc    = instr_valid ? queue_q[rd_ptr_q].pc    : 8'h00;
  assign queue_count = count_q;

  assign push = inflight_q & ~kill_q;
  assign pop  = instr_valid & instr_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    kill_d        = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    queue_d       = queue_q;
    if (redirect) begin
      // Redirect wins over any same-cycle push/pop; the response to a request
      // still outstanding at this edge is marked for discard.
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      kill_d     = inflight_q;
    end else begin
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + 8'd1;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        queue_d[wr_ptr_q] = '{instr: imem_data, pc: inflight_pc_q};
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= PC_RESET;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      kill_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      queue_q       <= queue_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with a small prefetch queue. It sits directly upstream of the CPU decode/control stage. It drives the instruction memory address, captures the returned 8-bit instruction words, and buffers them with their PCs. It hands them downstream over a valid/ready handshake, and flushes and re-steers on a redirect (taken jump/branch) from the PC-update logic.

## Interface
- DEPTH, 4, prefetch queue entries (power of 2, ≥2)
- PC_RESET, 8'h00, fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request this cycle; imem samples imem_addr at the rising edge
- imem_addr  out  8  instruction address for the current request (= fetch_pc)
- imem_data  in  8  instruction word, valid in the cycle after the request cycle
- instr  out  8  head-of-queue instruction
- instr_pc  out  8  PC of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  downstream accepts head this cycle
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  8  new fetch address
- queue_count  out  $clog2(DEPTH)+1  occupied queue entries

## Operation
- State:
  - fetch_pc (8b)
  - circular queue of DEPTH {instr, pc} entries with rd/wr pointers and count
  - inflight bit plus inflight_pc (8b) for the outstanding request
  - kill bit
- Issue: imem_req = rst_n & ~redirect & (count + inflight < DEPTH), combinational.
  - On issue: fetch_pc <= fetch_pc + 1, modulo 256 (FF wraps to 00).
  - Also on issue: inflight <= 1, inflight_pc <= fetch_pc.
  - With no issue: inflight <= 0.
- Capture: in any cycle with inflight=1 and kill=0, push {imem_data, inflight_pc} at wr pointer.
  - Occupancy gating means a push never finds the queue full.
- Pop: when instr_valid & instr_ready, advance rd pointer.
  - Push and pop in the same cycle leave count unchanged.
- Output: instr_valid = (count != 0).
  - instr/instr_pc come from the rd-pointer entry and hold stable while instr_valid & ~instr_ready.
  - No bypass: a captured word is visible the cycle after capture.
- Redirect, highest priority:
  - Clears count and pointers and sets fetch_pc <= redirect_pc.
  - No request is issued in the redirect cycle.
  - If inflight=1 at the redirect edge, sets kill <= 1 so that response is discarded.
  - Any concurrent pop or push is discarded.
  - kill clears the following cycle.
- Ordering: instructions leave in strictly increasing PC order (mod 256) between redirects, with no gaps or duplicates.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - fetch_pc=PC_RESET
  - count=0, pointers=0, inflight=0, kill=0
  - instr_valid=0, instr=8'h00, instr_pc=8'h00
  - queue_count=0, imem_req=0
- Reset asserted mid-operation drops all queued and in-flight words immediately.
- First request is in the first clock cycle after rst_n deasserts (cycle 0), with imem_addr=PC_RESET.
- Latency:
  - Request in cycle T → imem_data valid in T+1 → captured at the end of T+1 → instr_valid in T+2.
  - Redirect in cycle R → request to redirect_pc in R+1 → instr_valid with instr_pc=redirect_pc in R+3.
  - instr_valid is 0 in cycles R+1 and R+2.
- Throughput: with instr_ready held high, one instruction per cycle from cycle 2 onward.
- Backpressure: with instr_ready low, requests stop once count+inflight = DEPTH.
  - The queue then holds exactly DEPTH entries and imem_req stays 0.
  - Requests resume in the cycle after the first pop.

## Test plan
- Reset/stream:
  - Stimulus: PC_RESET=8'h00, imem model mem[a]=a^8'hA5, instr_ready=1.
  - Required: instr_valid first high in cycle 2 with instr=8'hA5, instr_pc=8'h00.
  - Then one instruction per cycle: pc 01, 02, 03…, each with instr=pc^8'hA5.
- Backpressure:
  - Stimulus: instr_ready=0 for 10 cycles after reset.
  - Required: queue_count reaches 4 and imem_req=0 from cycle 4 on; instr=8'hA5 and instr_pc=00 held stable.
  - Then raise instr_ready: pcs 00…07 delivered consecutively with no gap or duplicate.
- Redirect flush:
  - Stimulus: with 3 entries queued and a request in flight, pulse redirect with redirect_pc=8'h40.
  - Required: next cycle queue_count=0 and instr_valid=0.
  - The stale in-flight word never appears.
  - instr_pc=8'h40 with instr=8'hE5 is valid exactly 3 cycles after the redirect.
- Wrap-around:
  - Stimulus: redirect_pc=8'hFE with instr_ready=1.
  - Required: instr_pc sequence FE, FF, 00, 01.
- Redirect with simultaneous pop:
  - Stimulus: redirect while instr_valid & instr_ready.
  - Required: the popped word is consumed, nothing else is emitted until the redirect_pc word arrives, and queue_count=0 the next cycle.
- Async reset mid-run:
  - Stimulus: drop rst_n mid-cycle with a full queue.
  - Required: instr_valid=0, imem_req=0 and queue_count=0 before the next clock edge.
  - After release, fetch restarts at PC_RESET.
